line_cmd_sequencer: RTL

//  Upstream stage of the DrawLine rasteriser. Buffers line-draw commands in a small FIFO, presents one line's

---
 rtl/line_cmd_sequencer_pkg.sv | 17 +
 rtl/line_cmd_fifo.sv | 49 ++++
 rtl/line_cmd_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/line_cmd_sequencer_pkg.sv
// Shared types for the DrawLine command sequencer.
// Command word layout, MSB first: {CONT, X0, Y0, X1, Y1}.
package line_cmd_sequencer_pkg;

    localparam int COORD_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DRAW   = 2'd2
    } seq_state_t;

    function automatic int cmd_width(input int cw);
        return 1 + 4 * cw;
    endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// Synchronous show-ahead FIFO for line commands.
// Occupancy is a registered count so full/level never depend on this cycle's push.
module line_cmd_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 33,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             ACLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge ACLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign level = count;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/line_cmd_sequencer.sv
// Feeds queued line commands to the DrawLine rasteriser one line at a time,
// with polyline chaining and a per-line EN watchdog.
module line_cmd_sequencer
    import line_cmd_sequencer_pkg::*;
#(
    parameter  int DEPTH      = 8,
    parameter  int COORD_W    = COORD_W_DEF,
    parameter  int MAX_CYCLES = 512,
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic               ACLK,
    input  logic               RST,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic [COORD_W-1:0] CMD_X0,
    input  logic [COORD_W-1:0] CMD_Y0,
    input  logic [COORD_W-1:0] CMD_X1,
    input  logic [COORD_W-1:0] CMD_Y1,
    input  logic               CMD_CONT,
    output logic [COORD_W-1:0] X_0,
    output logic [COORD_W-1:0] Y_0,
    output logic [COORD_W-1:0] X_1,
    output logic [COORD_W-1:0] Y_1,
    output logic               EN,
    input  logic               DRAW_FINISH,
    output logic               BUSY,
    output logic               LINE_DONE,
    output logic               TIMEOUT_ERR,
    input  logic               CLR_ERR,
    output logic [LW-1:0]      LEVEL
);

    localparam int CMD_W = cmd_width(COORD_W);
    localparam int CW    = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYCLES);

    seq_state_t         state_q;
    seq_state_t         state_d;
    logic [CW-1:0]      cnt_q;
    logic [COORD_W-1:0] prev_x;
    logic [COORD_W-1:0] prev_y;
    logic               done_q;
    logic               err_q;

    logic [CMD_W-1:0]   fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               fin_seen;
    logic               wd_hit;

    logic               rd_cont;
    logic [COORD_W-1:0] rd_x0;
    logic [COORD_W-1:0] rd_y0;
    logic [COORD_W-1:0] rd_x1;
    logic [COORD_W-1:0] rd_y1;

    assign CMD_READY = !fifo_full;
    assign push      = CMD_VALID && CMD_READY;
    assign pop       = (state_q == IDLE) && !fifo_empty;

    line_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .ACLK  (ACLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .wdata ({CMD_CONT, CMD_X0, CMD_Y0, CMD_X1, CMD_Y1}),
        .rdata (fifo_rd),
        .level (LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {rd_cont, rd_x0, rd_y0, rd_x1, rd_y1} = fifo_rd;

    // Finish is stale from the previous line until the first pixel is issued.
    assign fin_seen = (cnt_q != '0) && DRAW_FINISH;
    assign wd_hit   = (cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        EN      = 1'b0;
        unique case (state_q)
            IDLE:   if (!fifo_empty) state_d = SETTLE;
            SETTLE: state_d = DRAW;
            DRAW: begin
                EN = !fin_seen && !wd_hit;
                if (fin_seen || wd_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_x  <= '0;
            prev_y  <= '0;
            X_0     <= '0;
            Y_0     <= '0;
            X_1     <= '0;
            Y_1     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == DRAW) && fin_seen;
            // A watchdog abort in the same cycle as CLR_ERR keeps the flag set.
            if ((state_q == DRAW) && wd_hit && !fin_seen) begin
                err_q <= 1'b1;
            end else if (CLR_ERR) begin
                err_q <= 1'b0;
            end
            if (pop) begin
                X_0    <= rd_cont ? prev_x : rd_x0;
                Y_0    <= rd_cont ? prev_y : rd_y0;
                X_1    <= rd_x1;
                Y_1    <= rd_y1;
                prev_x <= rd_x1;
                prev_y <= rd_y1;
                cnt_q  <= '0;
            end else if (state_q == DRAW) begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    assign BUSY        = (state_q != IDLE) || !fifo_empty;
    assign LINE_DONE   = done_q;
    assign TIMEOUT_ERR = err_q;

endmodule
